// File: rtl/mem_ctrl_pkg.sv
// Shared types and helpers for the byte-serial memory controller.
package mem_ctrl_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  // Access size codes, in bytes
  localparam logic [2:0] LEN_B = 3'd1;
  localparam logic [2:0] LEN_H = 3'd2;
  localparam logic [2:0] LEN_W = 3'd4;

  typedef enum logic [1:0] {
    MC_IDLE  = 2'd0,
    MC_READ  = 2'd1,
    MC_WRITE = 2'd2,
    MC_DONE  = 2'd3
  } mc_state_e;

  typedef enum logic {
    REQ_MEM = 1'b0,
    REQ_IF  = 1'b1
  } mc_req_e;

  // Any length code other than byte/half is served as a full word
  function automatic logic [2:0] norm_len(input logic [2:0] len);
    case (len)
      LEN_B:   return LEN_B;
      LEN_H:   return LEN_H;
      default: return LEN_W;
    endcase
  endfunction

  // Little-endian byte lane select
  function automatic logic [7:0] pick_byte(input logic [DATA_W-1:0] data, input logic [2:0] idx);
    case (idx)
      3'd0:    return data[7:0];
      3'd1:    return data[15:8];
      3'd2:    return data[23:16];
      3'd3:    return data[31:24];
      default: return 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/mem_ctrl_if.sv
// Pipeline request/response and byte-RAM signals of the memory controller.
interface mem_ctrl_if;
  import mem_ctrl_pkg::*;

  // MEM stage
  logic              load;
  logic              save;
  logic [ADDR_W-1:0] sl_address;
  logic [DATA_W-1:0] sl_data;
  logic [2:0]        sl_length;
  logic              sl_signed;
  logic              mem_done;
  logic [DATA_W-1:0] mem_data;
  // IF stage
  logic              if_req;
  logic [ADDR_W-1:0] if_address;
  logic              if_done;
  logic [DATA_W-1:0] if_inst;
  // Byte-wide synchronous RAM
  logic [7:0]        ram_din;
  logic [7:0]        ram_dout;
  logic [ADDR_W-1:0] ram_a;
  logic              ram_wr;

  modport slave (
    input  load, save, sl_address, sl_data, sl_length, sl_signed,
    input  if_req, if_address, ram_din,
    output mem_done, mem_data, if_done, if_inst, ram_dout, ram_a, ram_wr
  );

  modport master (
    output load, save, sl_address, sl_data, sl_length, sl_signed,
    output if_req, if_address, ram_din,
    input  mem_done, mem_data, if_done, if_inst, ram_dout, ram_a, ram_wr
  );

endinterface

// File: rtl/mem_ctrl_extend.sv
// Combinational zero/sign extension of an assembled little-endian load word.
module mem_ctrl_extend
  import mem_ctrl_pkg::*;
(
  input  logic [DATA_W-1:0] raw_i,
  input  logic [2:0]        len_i,
  input  logic              sgn_i,
  output logic [DATA_W-1:0] ext_o
);

  // Short loads ignore the unread upper bytes and fill from the top data bit
  always_comb begin
    ext_o = raw_i;
    case (len_i)
      LEN_B:   ext_o = {{24{sgn_i & raw_i[7]}}, raw_i[7:0]};
      LEN_H:   ext_o = {{16{sgn_i & raw_i[15]}}, raw_i[15:0]};
      default: ext_o = raw_i;
    endcase
  end

endmodule

// File: rtl/mem_ctrl.sv
// Memory controller: arbitrates MEM load/store and IF fetch, splits each
// access into byte beats on a 1-cycle-latency RAM and returns a done pulse.
module mem_ctrl
  import mem_ctrl_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  mem_ctrl_if.slave bus
);

  mc_state_e         state_q, state_d;
  logic [2:0]        beat_q, beat_d;
  logic [2:0]        len_q, len_d;
  logic              sgn_q, sgn_d;
  mc_req_e           req_q, req_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rbuf_q, rbuf_d;
  logic [DATA_W-1:0] ext_s;
  logic [ADDR_W-1:0] ram_a_q, ram_a_d;
  logic [7:0]        ram_dout_q, ram_dout_d;
  logic              ram_wr_q, ram_wr_d;
  logic              mem_done_q, mem_done_d;
  logic              if_done_q, if_done_d;
  logic [DATA_W-1:0] mem_data_q, mem_data_d;
  logic [DATA_W-1:0] if_inst_q, if_inst_d;

  mem_ctrl_extend u_extend (
    .raw_i (rbuf_d),
    .len_i (len_q),
    .sgn_i (sgn_q),
    .ext_o (ext_s)
  );

  // Read beat k (k>=1) returns the byte addressed in beat k-1
  always_comb begin
    rbuf_d = rbuf_q;
    if (state_q == MC_READ) begin
      case (beat_q)
        3'd1:    rbuf_d[7:0]   = bus.ram_din;
        3'd2:    rbuf_d[15:8]  = bus.ram_din;
        3'd3:    rbuf_d[23:16] = bus.ram_din;
        3'd4:    rbuf_d[31:24] = bus.ram_din;
        default: rbuf_d        = rbuf_q;
      endcase
    end else if (state_q == MC_IDLE) begin
      rbuf_d = 32'h0000_0000;
    end else begin
      rbuf_d = rbuf_q;
    end
  end

  // Next-state and registered-output logic; done pulses and ram_wr default low
  always_comb begin
    state_d    = state_q;
    beat_d     = beat_q;
    len_d      = len_q;
    sgn_d      = sgn_q;
    req_d      = req_q;
    wdata_d    = wdata_q;
    ram_a_d    = ram_a_q;
    ram_dout_d = ram_dout_q;
    ram_wr_d   = 1'b0;
    mem_done_d = 1'b0;
    if_done_d  = 1'b0;
    mem_data_d = mem_data_q;
    if_inst_d  = if_inst_q;
    case (state_q)
      MC_IDLE: begin
        if (bus.save) begin
          state_d    = MC_WRITE;
          req_d      = REQ_MEM;
          len_d      = norm_len(bus.sl_length);
          sgn_d      = bus.sl_signed;
          wdata_d    = bus.sl_data;
          ram_a_d    = bus.sl_address;
          ram_dout_d = bus.sl_data[7:0];
          ram_wr_d   = 1'b1;
          beat_d     = 3'd0;
        end else if (bus.load) begin
          state_d    = MC_READ;
          req_d      = REQ_MEM;
          len_d      = norm_len(bus.sl_length);
          sgn_d      = bus.sl_signed;
          ram_a_d    = bus.sl_address;
          beat_d     = 3'd0;
        end else if (bus.if_req) begin
          state_d    = MC_READ;
          req_d      = REQ_IF;
          len_d      = LEN_W;
          sgn_d      = 1'b0;
          ram_a_d    = bus.if_address;
          beat_d     = 3'd0;
        end else begin
          state_d    = MC_IDLE;
        end
      end
      MC_WRITE: begin
        if (beat_q == (len_q - 3'd1)) begin
          state_d    = MC_DONE;
          beat_d     = 3'd0;
          mem_done_d = 1'b1;
        end else begin
          beat_d     = beat_q + 3'd1;
          ram_a_d    = ram_a_q + 32'd1;
          ram_dout_d = pick_byte(wdata_q, beat_q + 3'd1);
          ram_wr_d   = 1'b1;
        end
      end
      MC_READ: begin
        if (beat_q == len_q) begin
          state_d = MC_DONE;
          beat_d  = 3'd0;
          if (req_q == REQ_IF) begin
            if_done_d  = 1'b1;
            if_inst_d  = ext_s;
          end else begin
            mem_done_d = 1'b1;
            mem_data_d = ext_s;
          end
        end else begin
          beat_d = beat_q + 3'd1;
          // Address stops advancing once the last byte has been issued
          if ((beat_q + 3'd1) < len_q) begin
            ram_a_d = ram_a_q + 32'd1;
          end else begin
            ram_a_d = ram_a_q;
          end
        end
      end
      MC_DONE: begin
        state_d = MC_IDLE;
      end
      default: begin
        state_d = MC_IDLE;
      end
    endcase
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= MC_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Beat counter, latched request fields and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      beat_q     <= 3'd0;
      len_q      <= 3'd0;
      sgn_q      <= 1'b0;
      req_q      <= REQ_MEM;
      wdata_q    <= 32'h0000_0000;
      rbuf_q     <= 32'h0000_0000;
      ram_a_q    <= 32'h0000_0000;
      ram_dout_q <= 8'h00;
      ram_wr_q   <= 1'b0;
      mem_done_q <= 1'b0;
      if_done_q  <= 1'b0;
      mem_data_q <= 32'h0000_0000;
      if_inst_q  <= 32'h0000_0000;
    end else begin
      beat_q     <= beat_d;
      len_q      <= len_d;
      sgn_q      <= sgn_d;
      req_q      <= req_d;
      wdata_q    <= wdata_d;
      rbuf_q     <= rbuf_d;
      ram_a_q    <= ram_a_d;
      ram_dout_q <= ram_dout_d;
      ram_wr_q   <= ram_wr_d;
      mem_done_q <= mem_done_d;
      if_done_q  <= if_done_d;
      mem_data_q <= mem_data_d;
      if_inst_q  <= if_inst_d;
    end
  end

  assign bus.ram_a    = ram_a_q;
  assign bus.ram_dout = ram_dout_q;
  assign bus.ram_wr   = ram_wr_q;
  assign bus.mem_done = mem_done_q;
  assign bus.mem_data = mem_data_q;
  assign bus.if_done  = if_done_q;
  assign bus.if_inst  = if_inst_q;

endmodule
